instr_split_queue: RTL and testbench
====================================

INSTR_SPLIT_QUEUE -- requirements
Module: instr_split_queue

Interface
REQ-001 Parameter XLEN, default 32, width of the extended immediate; legal values 32 and 64.
REQ-002 Parameter DEPTH, default 4, instruction queue entries; power of two, 2 to 16.
REQ-003 Parameter PC_W, default 32, width of the program-counter tag.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  producer offers in_instr/in_pc this cycle.
REQ-007 in_ready  output  1  queue accepts an entry this cycle.
REQ-008 in_instr  input  32  MIPS instruction word.
REQ-009 in_pc  input  PC_W  address tag of in_instr.
REQ-010 flush  input  1  synchronous discard of all queued entries.
REQ-011 out_valid  output  1  head entry present and decoded.
REQ-012 out_ready  input  1  consumer takes the head entry this cycle.
REQ-013 out_pc  output  PC_W  tag of head entry.
REQ-014 op, rs, rt, rd, shamt, funct  output  6/5/5/5/5/6  fields [31:26], [25:21], [20:16], [15:11], [10:6], [5:0] of head entry.
REQ-015 imm16  output  16  field [15:0] of head entry.
REQ-016 imm_ext  output  XLEN  extended immediate per REQ-027.
REQ-017 jtarget  output  26  field [25:0] of head entry.
REQ-018 fmt  output  2  instruction format: 0 R, 1 I, 2 J; 3 never driven.
REQ-019 count  output  clog2(DEPTH)+1  number of queued entries.

Function
REQ-020 Push occurs when in_valid and in_ready are both 1 at a rising edge; pop occurs when out_valid and out_ready are both 1.
REQ-021 in_ready shall equal (count < DEPTH); it is independent of out_ready (no push at full even with simultaneous pop).
REQ-022 out_valid shall equal (count != 0); no fall-through: an entry pushed at edge N is visible at outputs after edge N, never in the same cycle.
REQ-023 Simultaneous push and pop with 0 < count < DEPTH keeps count unchanged and preserves FIFO order.
REQ-024 Read and write pointers wrap modulo DEPTH; order is preserved across wrap.
REQ-025 flush at an edge sets count and both pointers to 0; flush has priority over push and pop in the same cycle; the offered entry is dropped.
REQ-026 All decoded outputs are combinational functions of the head entry's stored registers only; when out_valid is 0, op through jtarget, out_pc and fmt shall be 0.
REQ-027 imm_ext: op 0x0C/0x0D/0x0E (ANDI/ORI/XORI) zero-extend imm16; op 0x0F (LUI) gives {imm16,16'b0} sign-extended to XLEN; all other ops sign-extend imm16.
REQ-028 fmt: op 0x00 gives 0; op 0x02 or 0x03 gives 2; all other ops give 1.
REQ-029 Field extraction bits are fixed regardless of XLEN; only imm_ext width changes.
REQ-030 Outputs shall hold stable while out_valid is 1 and out_ready is 0.

Reset
REQ-031 rst_n low immediately forces count 0, pointers 0, out_valid 0, in_ready 1, all decoded outputs 0, independent of clk.
REQ-032 Reset asserted mid-operation discards all entries; first push after rst_n deassertion is accepted on the first rising edge.
REQ-033 Storage array contents need not be reset; they are unobservable while count is 0.

Verification
REQ-034 Push 0x012A4020 (add $t0,$t1,$t2), pc 0x100 -> next cycle out_valid 1, op 0, rs 9, rt 10, rd 8, shamt 0, funct 0x20, fmt 0, out_pc 0x100.
REQ-035 Push 0x2008FFFF (addi) then 0x3408FFFF (ori), XLEN 32 -> imm_ext 0xFFFFFFFF then 0x0000FFFF, fmt 1 both; push 0x3C081234 (lui) -> imm_ext 0x12340000.
REQ-036 Push 0x0C000010 (jal) -> fmt 2, jtarget 0x0000010; XLEN 64 with 0x2008FFFF -> imm_ext 0xFFFFFFFFFFFFFFFF.
REQ-037 DEPTH 4, out_ready 0, push 5 consecutive -> count 4, in_ready 0, fifth not accepted; then out_ready 1 -> entries 1-4 in order, count reaches 0.
REQ-038 Count 2 with simultaneous push/pop for 10 cycles -> count stays 2, order preserved through pointer wrap; flush with in_valid 1 -> count 0, out_valid 0 next cycle.
REQ-039 rst_n low asynchronously with count 3 -> out_valid 0 and count 0 before next clk edge; all decoded outputs 0.

Source files
------------

// File: rtl/instr_split_queue.sv
// Instruction queue with MIPS field split: buffers instruction/pc pairs and
// presents the head entry with its fields, extended immediate and format decoded.
module instr_split_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_instr,
   input  logic [PC_W-1:0]          in_pc,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PC_W-1:0]          out_pc,
   output logic [5:0]               op,
   output logic [4:0]               rs,
   output logic [4:0]               rt,
   output logic [4:0]               rd,
   output logic [4:0]               shamt,
   output logic [5:0]               funct,
   output logic [15:0]              imm16,
   output logic [XLEN-1:0]          imm_ext,
   output logic [25:0]              jtarget,
   output logic [1:0]               fmt,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [31:0]     instr_mem [DEPTH];
   logic [PC_W-1:0] pc_mem    [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            push;
   logic            pop;
   logic [31:0]     head;
   logic [XLEN-1:0] imm_sx;

   // Handshake: a side transfers on a rising edge where its valid and ready are
   // both 1; in_ready ignores out_ready, and flush cancels both transfers.
   assign in_ready  = (count < FULL);
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr] <= in_instr;
         pc_mem[wr_ptr]    <= in_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Gating on out_valid keeps every decoded output at 0 while the queue is empty,
   // so stale storage is never visible.
   assign head    = out_valid ? instr_mem[rd_ptr] : '0;
   assign out_pc  = out_valid ? pc_mem[rd_ptr] : '0;
   assign op      = head[31:26];
   assign rs      = head[25:21];
   assign rt      = head[20:16];
   assign rd      = head[15:11];
   assign shamt   = head[10:6];
   assign funct   = head[5:0];
   assign imm16   = head[15:0];
   assign jtarget = head[25:0];
   assign imm_sx  = {{(XLEN-16){head[15]}}, head[15:0]};

   always_comb begin
      imm_ext = imm_sx;
      case (op)
         6'h0C, 6'h0D, 6'h0E: imm_ext = {{(XLEN-16){1'b0}}, head[15:0]};
         6'h0F:               imm_ext = imm_sx << 16;
         default:             imm_ext = imm_sx;
      endcase
   end

   always_comb begin
      fmt = 2'd1;
      case (op)
         6'h00:        fmt = 2'd0;
         6'h02, 6'h03: fmt = 2'd2;
         default:      fmt = 2'd1;
      endcase
   end

endmodule

// File: tb/tb_instr_split_queue.sv
// Bench for instr_split_queue: directed scenarios plus random traffic, checked
// against a queue-based reference model; a 64-bit instance checks wide imm_ext.
module tb_instr_split_queue;

   localparam int DEPTH = 4;
   localparam int PC_W  = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rst_n;
   logic in_valid;
   logic [31:0] in_instr;
   logic [PC_W-1:0] in_pc;
   logic flush;
   logic out_ready;

   logic in_ready, out_valid;
   logic [PC_W-1:0] out_pc;
   logic [5:0] op, funct;
   logic [4:0] rs, rt, rd, shamt;
   logic [15:0] imm16;
   logic [31:0] imm_ext;
   logic [25:0] jtarget;
   logic [1:0] fmt;
   logic [CW-1:0] count;

   logic in_ready_b, out_valid_b;
   logic [PC_W-1:0] out_pc_b;
   logic [5:0] op_b, funct_b;
   logic [4:0] rs_b, rt_b, rd_b, shamt_b;
   logic [15:0] imm16_b;
   logic [63:0] imm_ext_b;
   logic [25:0] jtarget_b;
   logic [1:0] fmt_b;
   logic [CW-1:0] count_b;

   int checks = 0;
   int errors = 0;

   // reference model: queued instruction words and pcs, head at index 0
   logic [31:0]     q_instr[$];
   logic [PC_W-1:0] q_pc[$];

   always #5 clk = ~clk;

   instr_split_queue #(.XLEN(32), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .op(op), .rs(rs), .rt(rt), .rd(rd),
      .shamt(shamt), .funct(funct), .imm16(imm16), .imm_ext(imm_ext),
      .jtarget(jtarget), .fmt(fmt), .count(count)
   );

   instr_split_queue #(.XLEN(64), .DEPTH(DEPTH), .PC_W(PC_W)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid_b),
      .out_ready(out_ready), .out_pc(out_pc_b), .op(op_b), .rs(rs_b), .rt(rt_b),
      .rd(rd_b), .shamt(shamt_b), .funct(funct_b), .imm16(imm16_b),
      .imm_ext(imm_ext_b), .jtarget(jtarget_b), .fmt(fmt_b), .count(count_b)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_imm(input logic [31:0] ins);
      logic [15:0] i16;
      longint v;
      i16 = ins[15:0];
      case (ins[31:26])
         6'h0C, 6'h0D, 6'h0E: v = longint'(i16);
         6'h0F:               v = longint'(int'({i16, 16'h0000}));
         default:             v = longint'(shortint'(i16));
      endcase
      return v;
   endfunction

   function automatic logic [1:0] ref_fmt(input logic [31:0] ins);
      if (ins[31:26] == 6'h00) return 2'd0;
      if (ins[31:26] == 6'h02 || ins[31:26] == 6'h03) return 2'd2;
      return 2'd1;
   endfunction

   task automatic check_all(input string tag);
      logic [31:0] h;
      logic [PC_W-1:0] p;
      logic [63:0] e_imm;
      logic [1:0] e_fmt;
      int n;
      n = q_instr.size();
      h = (n > 0) ? q_instr[0] : 32'h0;
      p = (n > 0) ? q_pc[0] : '0;
      e_imm = (n > 0) ? ref_imm(h) : 64'h0;
      e_fmt = (n > 0) ? ref_fmt(h) : 2'd0;
      chk({tag, ".count"}, count, n);
      chk({tag, ".in_ready"}, in_ready, n < DEPTH);
      chk({tag, ".out_valid"}, out_valid, n != 0);
      chk({tag, ".fields"}, {op, rs, rt, rd, shamt, funct}, h);
      chk({tag, ".imm16"}, imm16, h[15:0]);
      chk({tag, ".jtarget"}, jtarget, h[25:0]);
      chk({tag, ".fmt"}, fmt, e_fmt);
      chk({tag, ".out_pc"}, out_pc, p);
      chk({tag, ".imm_ext32"}, imm_ext, e_imm[31:0]);
      chk({tag, ".b_ctrl"}, {count_b, in_ready_b, out_valid_b}, {CW'(n), n < DEPTH, n != 0});
      chk({tag, ".b_fields"}, {op_b, rs_b, rt_b, rd_b, shamt_b, funct_b, imm16_b, jtarget_b, fmt_b, out_pc_b},
          {h, h[15:0], h[25:0], e_fmt, p});
      chk({tag, ".imm_ext64"}, imm_ext_b, e_imm);
   endtask

   // drive one cycle of inputs, advance the model at the edge, then check
   task automatic step(input string tag, input logic v, input logic [31:0] ins,
                       input logic [PC_W-1:0] pc, input logic ordy, input logic fl);
      bit do_push, do_pop;
      in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
      do_push = v && (q_instr.size() < DEPTH);
      do_pop  = ordy && (q_instr.size() > 0);
      @(posedge clk);
      #1;
      if (fl) begin
         q_instr.delete(); q_pc.delete();
      end else begin
         if (do_pop) begin
            void'(q_instr.pop_front()); void'(q_pc.pop_front());
         end
         if (do_push) begin
            q_instr.push_back(ins); q_pc.push_back(pc);
         end
      end
      check_all(tag);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] ops [10] = '{6'h00, 6'h02, 6'h03, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h08, 6'h23, 6'h2B};
      logic [31:0] r;
      logic [5:0] o;
      r = $urandom();
      o = ($urandom_range(0, 9) == 9) ? 6'($urandom()) : ops[$urandom_range(0, 9)];
      return {o, r[25:0]};
   endfunction

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
      #3;
      check_all("reset");
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;

      // R-type decode
      step("add_push", 1'b1, 32'h012A4020, 32'h100, 1'b0, 1'b0);
      chk("add.rs", rs, 5'd9);
      chk("add.rt", rt, 5'd10);
      chk("add.rd", rd, 5'd8);
      chk("add.funct", funct, 6'h20);
      chk("add.pc", out_pc, 32'h100);
      step("add_pop", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // immediate extension and J format
      step("addi_push", 1'b1, 32'h2008FFFF, 32'h104, 1'b0, 1'b0);
      chk("addi.imm32", imm_ext, 32'hFFFFFFFF);
      chk("addi.imm64", imm_ext_b, 64'hFFFFFFFFFFFFFFFF);
      step("ori_push", 1'b1, 32'h3408FFFF, 32'h108, 1'b0, 1'b0);
      step("lui_push", 1'b1, 32'h3C081234, 32'h10C, 1'b0, 1'b0);
      step("jal_push", 1'b1, 32'h0C000010, 32'h110, 1'b0, 1'b0);
      step("pop_addi", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("ori.imm32", imm_ext, 32'h0000FFFF);
      chk("ori.fmt", fmt, 2'd1);
      step("pop_ori", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("lui.imm32", imm_ext, 32'h12340000);
      step("pop_lui", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("jal.fmt", fmt, 2'd2);
      chk("jal.jtarget", jtarget, 26'h0000010);
      step("pop_jal", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // fill past full with consumer stalled, then drain in order
      for (int i = 1; i <= 5; i++)
         step("fill", 1'b1, 32'h20000000 + 32'(i), 32'(i * 4), 1'b0, 1'b0);
      chk("full.in_ready", in_ready, 1'b0);
      step("full_pushpop", 1'b1, 32'h20000099, 32'h99, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++)
         step("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // steady push+pop at count 2 across pointer wrap, then flush beats push
      step("pp_a", 1'b1, 32'h24010001, 32'h200, 1'b0, 1'b0);
      step("pp_b", 1'b1, 32'h24010002, 32'h204, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++)
         step("pushpop", 1'b1, 32'h24020000 + 32'(i), 32'h300 + 32'(i * 4), 1'b1, 1'b0);
      chk("pushpop.count", count, CW'(2));
      step("flush", 1'b1, 32'h24030000, 32'h400, 1'b1, 1'b1);

      // asynchronous reset with entries queued
      for (int i = 0; i < 3; i++)
         step("pre_rst", 1'b1, 32'h8C000000 + 32'(i), 32'h500 + 32'(i), 1'b0, 1'b0);
      in_valid = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      q_instr.delete(); q_pc.delete();
      check_all("async_rst");
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      step("post_rst", 1'b1, 32'h3C01ABCD, 32'h600, 1'b0, 1'b0);

      // random traffic
      for (int i = 0; i < 400; i++)
         step("rand", 1'($urandom_range(0, 3) != 0), rand_instr(), 32'($urandom()),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
